// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wr_ready back-pressure and registered read strobe
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic                  wr_ready,
  output logic                  rd_val,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign wr_ready = !full;
  assign wr_acc   = wr_en && !full;
  assign rd_acc   = rd_en && !empty;

  // Storage is deliberately left out of reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_val  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_val <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - table vectors plus queue scoreboard for sync_fifo
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          wr_ready;
  logic          rd_val;
  logic [DW-1:0] rd_data;

  int checks = 0;
  int passed = 0;

  logic [DW-1:0] sb_q[$];
  logic          exp_val = 1'b0;
  logic [DW-1:0] exp_data = '0;

  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    logic          r;
    logic          e_rdy;
    logic          e_val;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs[10];

  sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rd_en(rd_en),
    .wr_ready(wr_ready),
    .rd_val(rd_val),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Drive one cycle; the scoreboard decides acceptance from pre-edge occupancy.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input string name);
    int n;
    wr_en = w;
    wr_data = d;
    rd_en = r;
    @(posedge clk);
    n = sb_q.size();
    if (r && n > 0) begin
      exp_val = 1'b1;
      exp_data = sb_q.pop_front();
    end else begin
      exp_val = 1'b0;
    end
    if (w && n < DEPTH) sb_q.push_back(d);
    #1;
    chk({name, " rd_val"}, 32'(rd_val), 32'(exp_val));
    chk({name, " rd_data"}, 32'(rd_data), 32'(exp_data));
    chk({name, " wr_ready"}, 32'(wr_ready), 32'(sb_q.size() < DEPTH));
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (sb_q.size() > 0 && guard < 4 * DEPTH) begin
      cyc(1'b0, '0, 1'b1, name);
      guard++;
    end
    cyc(1'b0, '0, 1'b1, {name, " tail"});
  endtask

  initial begin
    // Basic order: write 0..3 then six reads; expected values written out by hand.
    for (int i = 0; i < 4; i++) vecs[i] = '{1'b1, DW'(i), 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h03};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h03};

    repeat (2) @(posedge clk);
    #1;
    chk("reset wr_ready", 32'(wr_ready), 32'd1);
    chk("reset rd_val", 32'(rd_val), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'd0);
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, "empty read");

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].w, vecs[i].d, vecs[i].r, "order sb");
      chk("order tbl rd_val", 32'(rd_val), 32'(vecs[i].e_val));
      chk("order tbl rd_data", 32'(rd_data), 32'(vecs[i].e_data));
      chk("order tbl wr_ready", 32'(wr_ready), 32'(vecs[i].e_rdy));
    end

    // Full: eight words fill it, the ninth is dropped.
    for (int i = 0; i < 8; i++) cyc(1'b1, DW'(8'h10 + i), 1'b0, "fill");
    chk("full wr_ready", 32'(wr_ready), 32'd0);
    cyc(1'b1, 8'hFF, 1'b0, "write when full");
    drain("full drain");

    // Wrap-around across the pointer boundary.
    for (int i = 0; i < 6; i++) cyc(1'b1, DW'(8'h20 + i), 1'b0, "wrap w6");
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1, "wrap r6");
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'h30 + i), 1'b0, "wrap w5");
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, "wrap r5");

    // Simultaneous read/write at occupancy 3.
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(8'h40 + i), 1'b0, "sim pre");
    for (int i = 0; i < 10; i++) cyc(1'b1, DW'(8'h50 + i), 1'b1, "sim rw");
    chk("sim occupancy", 32'(sb_q.size()), 32'd3);
    drain("sim drain");

    // Simultaneous read/write while full: read proceeds, write lost.
    for (int i = 0; i < 8; i++) cyc(1'b1, DW'(8'h60 + i), 1'b0, "full2 fill");
    cyc(1'b1, 8'hEE, 1'b1, "full rw");
    chk("full rw occupancy", 32'(sb_q.size()), 32'd7);
    drain("full rw drain");

    // Reset mid-operation, asserted between edges.
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'h70 + i), 1'b0, "mid store");
    cyc(1'b0, '0, 1'b1, "mid read one");
    #2 reset = 1'b1;
    #1;
    chk("mid reset wr_ready", 32'(wr_ready), 32'd1);
    chk("mid reset rd_val", 32'(rd_val), 32'd0);
    chk("mid reset rd_data", 32'(rd_data), 32'd0);
    sb_q.delete();
    exp_val = 1'b0;
    exp_data = '0;
    #1 reset = 1'b0;
    cyc(1'b0, '0, 1'b1, "post reset read");
    cyc(1'b1, 8'hAA, 1'b0, "post reset write");
    cyc(1'b0, '0, 1'b1, "post reset readback");
    chk("post reset AA", 32'(rd_data), 32'hAA);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
